pcie2_pipe_rx_cond: RTL

// Parametrised, multi-lane PIPE receive-side conditioner on the PCLK domain, fed by post-CTC SERDES lanes.
// Per lane: aligns RxValid to a COMMA, delays and masks RxElecIdle, and overrides RxStatus with the

---
 rtl/pcie2_pipe_rx_cond_if.sv | 41 ++++
 rtl/pcie2_pipe_rx_cond.sv | 66 ++++++
 2 files changed

// File: rtl/pcie2_pipe_rx_cond_if.sv
// pcie2_pipe_rx_cond_if: PIPE RX conditioner bus; err_clr/err_cnt exist only with PIPE_RX_ERRCNT_EN
interface pcie2_pipe_rx_cond_if #(parameter int LANES = 1, parameter int BYTES = 2);
  localparam int DW = 8 * BYTES;
  logic                   start_mask;
  logic                   detsm_done;
  logic [LANES-1:0]       pcie_con;
  logic [1:0]             PowerDown;
  logic                   TxDetectRx_Loopback;
  logic [LANES*BYTES-1:0] TxElecIdle_in;
  logic [LANES*DW-1:0]    RxData_in;
  logic [LANES*BYTES-1:0] RxDataK_in;
  logic [LANES*3-1:0]     RxStatus_in;
  logic [LANES-1:0]       RxValid_in;
  logic [LANES-1:0]       RxElecIdle_in;
  logic [LANES*DW-1:0]    RxData_out;
  logic [LANES*BYTES-1:0] RxDataK_out;
  logic [LANES*3-1:0]     RxStatus_out;
  logic [LANES-1:0]       RxValid_out;
  logic [LANES-1:0]       RxElecIdle_out;
  logic [LANES-1:0]       ffc_fb_loopback;
`ifdef PIPE_RX_ERRCNT_EN
  logic                   err_clr;
  logic [LANES*8-1:0]     err_cnt;
`endif
  modport master (
    output start_mask, detsm_done, pcie_con, PowerDown, TxDetectRx_Loopback, TxElecIdle_in,
           RxData_in, RxDataK_in, RxStatus_in, RxValid_in, RxElecIdle_in,
    input  RxData_out, RxDataK_out, RxStatus_out, RxValid_out, RxElecIdle_out, ffc_fb_loopback
`ifdef PIPE_RX_ERRCNT_EN
    , output err_clr, input err_cnt
`endif
  );
  modport slave (
    input  start_mask, detsm_done, pcie_con, PowerDown, TxDetectRx_Loopback, TxElecIdle_in,
           RxData_in, RxDataK_in, RxStatus_in, RxValid_in, RxElecIdle_in,
    output RxData_out, RxDataK_out, RxStatus_out, RxValid_out, RxElecIdle_out, ffc_fb_loopback
`ifdef PIPE_RX_ERRCNT_EN
    , input err_clr, output err_cnt
`endif
  );
endinterface

// File: rtl/pcie2_pipe_rx_cond.sv
// pcie2_pipe_rx_cond: per-lane PIPE RX valid/elecidle/status conditioning; PIPE_RX_ERRCNT_EN adds decode-error counters
module pcie2_pipe_rx_cond #(
  parameter int         LANES     = 1,
  parameter int         BYTES     = 2,
  parameter int         VALID_DLY = 21,
  parameter int         EI_DLY    = 21,
  parameter logic [7:0] COMMA     = 8'hBC
) (
  input logic PCLK,
  input logic RESET,
  pcie2_pipe_rx_cond_if.slave p
);
  localparam int DW = 8 * BYTES;
  typedef enum logic {INVALID = 1'b0, VALID = 1'b1} state_t;
  state_t [LANES-1:0] st, st_n;
  logic [LANES-1:0][VALID_DLY-1:0] vsr;
  logic [LANES-1:0][EI_DLY-1:0] esr;
  logic [1:0] sm;
  always_comb begin
    st_n = st;
    p.RxValid_out = '0;
    for (int l = 0; l < LANES; l++) begin
      logic hit;
      hit = 1'b0;
      for (int b = 0; b < BYTES; b++)
        hit = hit | (p.RxDataK_in[l*BYTES+b] && p.RxData_in[l*DW+b*8 +: 8] == COMMA);
      st_n[l] = !vsr[l][VALID_DLY-1] ? INVALID : (st[l] == VALID || hit) ? VALID : INVALID;
      p.RxValid_out[l] = st[l] == VALID;
    end
  end
  always_ff @(posedge PCLK) begin
    if (RESET) begin
      for (int l = 0; l < LANES; l++) st[l] <= INVALID;
      vsr <= '0;
      esr <= '1;
      sm <= '0;
      p.RxData_out <= '0;
      p.RxDataK_out <= '0;
      p.RxStatus_out <= '0;
      p.RxElecIdle_out <= '1;
      p.ffc_fb_loopback <= '0;
    end else begin
      st <= st_n;
      sm <= {sm[0], p.start_mask};
      p.RxData_out <= p.RxData_in;
      p.RxDataK_out <= p.RxDataK_in;
      for (int l = 0; l < LANES; l++) begin
        vsr[l] <= (vsr[l] << 1) | VALID_DLY'(p.RxValid_in[l]);
        esr[l] <= (esr[l] << 1) | EI_DLY'(p.RxElecIdle_in[l]);
        p.RxElecIdle_out[l] <= esr[l][EI_DLY-1] | sm[1];
        p.RxStatus_out[l*3 +: 3] <= p.detsm_done ? (p.pcie_con[l] ? 3'b011 : 3'b000) : p.RxStatus_in[l*3 +: 3];
        p.ffc_fb_loopback[l] <= p.PowerDown == 2'b00 && p.TxDetectRx_Loopback && ~|p.TxElecIdle_in[l*BYTES +: BYTES];
      end
    end
  end
`ifdef PIPE_RX_ERRCNT_EN
  always_ff @(posedge PCLK) begin
    if (RESET || p.err_clr)
      p.err_cnt <= '0;
    else
      for (int l = 0; l < LANES; l++)
        if (p.RxValid_out[l] && p.RxStatus_out[l*3 +: 3] == 3'b100 && p.err_cnt[l*8 +: 8] != 8'hFF)
          p.err_cnt[l*8 +: 8] <= p.err_cnt[l*8 +: 8] + 8'd1;
  end
`endif
endmodule
